// File: rtl/ftl_arb_pkg.sv
// ftl_arb_pkg: shared types and helpers for the FTL request arbiter.
//   state_e                - arbiter FSM state encoding
//   DEFAULT_TIMEOUT_CYCLES - default WAIT-state watchdog limit
//   id_width()             - width of an encoded requester id
package ftl_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_RESP  = 3'd3,
        ST_DRAIN = 3'd4
    } state_e;

    localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

    // A single requester still needs a 1-bit id field.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ftl_req_arbiter_if.sv
// ftl_req_arbiter_if: bundle of the requester-side and FTL-side signals of
// the FTL request arbiter.
//   master - requesters plus FTL (drive requests and FTL responses)
//   slave  - the arbiter (drives grants, responses and the FTL issue port)
// Handshake: a request transfers on a rising edge where req_valid[i] and
// req_ready[i] are both high; req_ready is combinational from req_valid, so
// a requester holds valid, addr and rw stable until it sees ready.
interface ftl_req_arbiter_if #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 32
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ-1:0]            req_rw;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic [ADDR_WIDTH-1:0]         rsp_addr;
    logic                          rsp_hit;
    logic                          rsp_err;
    logic [ADDR_WIDTH-1:0]         ftl_addr;
    logic                          ftl_addr_valid;
    logic                          ftl_rw;
    logic [ADDR_WIDTH-1:0]         ftl_new_addr;
    logic                          ftl_addr_resp;
    logic                          ftl_cache_hit;

    modport master (
        output req_valid, req_addr, req_rw, ftl_new_addr, ftl_addr_resp, ftl_cache_hit,
        input  req_ready, rsp_valid, rsp_addr, rsp_hit, rsp_err, ftl_addr, ftl_addr_valid, ftl_rw
    );

    modport slave (
        input  req_valid, req_addr, req_rw, ftl_new_addr, ftl_addr_resp, ftl_cache_hit,
        output req_ready, rsp_valid, rsp_addr, rsp_hit, rsp_err, ftl_addr, ftl_addr_valid, ftl_rw
    );
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin grant.
//   ptr_i      - id of the last granted requester; search starts at ptr_i+1
//   req_i      - request vector
//   gnt_o      - one-hot grant (all zero when nothing requests)
//   gnt_id_o   - encoded id of the granted requester
//   gnt_any_o  - some requester is granted
module rr_arbiter
    import ftl_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = id_width(NUM_REQ)
) (
    input  logic [ID_W-1:0]    ptr_i,
    input  logic [NUM_REQ-1:0] req_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]    gnt_id_o,
    output logic               gnt_any_o
);

    int idx;

    // Scan ptr+1 .. ptr+NUM_REQ (wrapping); ptr itself is visited last.
    always_comb begin
        gnt_o     = '0;
        gnt_id_o  = '0;
        gnt_any_o = 1'b0;
        idx       = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = int'(ptr_i) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!gnt_any_o && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                gnt_id_o   = ID_W'(idx);
                gnt_any_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ftl_req_arbiter.sv
// ftl_req_arbiter: shares one FTL address-translation port among NUM_REQ
// requesters, one translation in flight, round-robin grant.
//   req_*        - per-requester request handshake (valid/ready, addr, rw)
//   rsp_*        - one-cycle response pulse to the owner; addr/hit/err shared
//   ftl_*        - issue pulse plus held addr/rw to the FTL, and its response
//   busy_o       - FSM not idle
//   proto_err_o  - sticky: FTL responded when nothing was outstanding
//   hit/miss_cnt - saturating counters of FTL cache hits and misses
//   dbg_state_o  - current FSM state
module ftl_req_arbiter
    import ftl_arb_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
    input  logic [NUM_REQ-1:0]            req_rw_i,
    output logic [NUM_REQ-1:0]            rsp_valid_o,
    output logic [ADDR_WIDTH-1:0]         rsp_addr_o,
    output logic                          rsp_hit_o,
    output logic                          rsp_err_o,
    output logic [ADDR_WIDTH-1:0]         ftl_addr_o,
    output logic                          ftl_addr_valid_o,
    output logic                          ftl_rw_o,
    input  logic [ADDR_WIDTH-1:0]         ftl_new_addr_i,
    input  logic                          ftl_addr_resp_i,
    input  logic                          ftl_cache_hit_i,
    output logic                          busy_o,
    output logic                          proto_err_o,
    output logic [CNT_WIDTH-1:0]          hit_cnt_o,
    output logic [CNT_WIDTH-1:0]          miss_cnt_o,
    output state_e                        dbg_state_o
);

    localparam int ID_W = id_width(NUM_REQ);
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    state_e                state_q, state_d;
    logic [ID_W-1:0]       ptr_q, ptr_d, owner_q, owner_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d, rsp_addr_q, rsp_addr_d;
    logic                  rw_q, rw_d, rsp_hit_q, rsp_hit_d;
    logic                  rsp_err_q, rsp_err_d, proto_err_q, proto_err_d;
    logic [WD_W-1:0]       wd_q, wd_d;
    logic [CNT_WIDTH-1:0]  hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

    logic [NUM_REQ-1:0]    gnt;
    logic [ID_W-1:0]       gnt_id;
    logic                  gnt_any;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic                  sel_rw;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rr (
        .ptr_i    (ptr_q),
        .req_i    (req_valid_i),
        .gnt_o    (gnt),
        .gnt_id_o (gnt_id),
        .gnt_any_o(gnt_any)
    );

    always_comb begin
        sel_addr = '0;
        sel_rw   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                sel_addr = req_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_rw   = req_rw_i[i];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        addr_d      = addr_q;
        rw_d        = rw_q;
        rsp_addr_d  = rsp_addr_q;
        rsp_hit_d   = rsp_hit_q;
        rsp_err_d   = rsp_err_q;
        proto_err_d = proto_err_q;
        wd_d        = wd_q;
        hit_cnt_d   = hit_cnt_q;
        miss_cnt_d  = miss_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (gnt_any) begin
                    addr_d  = sel_addr;
                    rw_d    = sel_rw;
                    owner_d = gnt_id;
                    ptr_d   = gnt_id;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                wd_d    = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A response in the final watchdog cycle beats the timeout.
                if (ftl_addr_resp_i) begin
                    rsp_addr_d = ftl_new_addr_i;
                    rsp_hit_d  = ftl_cache_hit_i;
                    rsp_err_d  = 1'b0;
                    if (ftl_cache_hit_i) begin
                        if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + CNT_WIDTH'(1);
                    end else begin
                        if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + CNT_WIDTH'(1);
                    end
                    state_d = ST_RESP;
                end else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    rsp_addr_d = '0;
                    rsp_hit_d  = 1'b0;
                    rsp_err_d  = 1'b1;
                    state_d    = ST_RESP;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            ST_RESP: begin
                // After a timeout the FTL still owes a response; swallow it.
                state_d = rsp_err_q ? ST_DRAIN : ST_IDLE;
            end
            ST_DRAIN: begin
                if (ftl_addr_resp_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (ftl_addr_resp_i &&
            (state_q == ST_IDLE || state_q == ST_ISSUE || state_q == ST_RESP)) begin
            proto_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            ptr_q       <= ID_W'(NUM_REQ - 1);
            owner_q     <= '0;
            addr_q      <= '0;
            rw_q        <= 1'b0;
            rsp_addr_q  <= '0;
            rsp_hit_q   <= 1'b0;
            rsp_err_q   <= 1'b0;
            proto_err_q <= 1'b0;
            wd_q        <= '0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            addr_q      <= addr_d;
            rw_q        <= rw_d;
            rsp_addr_q  <= rsp_addr_d;
            rsp_hit_q   <= rsp_hit_d;
            rsp_err_q   <= rsp_err_d;
            proto_err_q <= proto_err_d;
            wd_q        <= wd_d;
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
        end
    end

    // Ready is gated by reset so every output reads 0 while reset is held.
    assign req_ready_o = (state_q == ST_IDLE && !rst_i) ? gnt : '0;

    always_comb begin
        rsp_valid_o = '0;
        if (state_q == ST_RESP) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (owner_q == ID_W'(i)) rsp_valid_o[i] = 1'b1;
            end
        end
    end

    assign rsp_addr_o       = rsp_addr_q;
    assign rsp_hit_o        = rsp_hit_q;
    assign rsp_err_o        = rsp_err_q;
    assign ftl_addr_o       = addr_q;
    assign ftl_rw_o         = rw_q;
    assign ftl_addr_valid_o = (state_q == ST_ISSUE);
    assign busy_o           = (state_q != ST_IDLE);
    assign proto_err_o      = proto_err_q;
    assign hit_cnt_o        = hit_cnt_q;
    assign miss_cnt_o       = miss_cnt_q;
    assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_ftl_req_arbiter.sv
// tb_ftl_req_arbiter: directed bench for ftl_req_arbiter with
// NUM_REQ=2, ADDR_WIDTH=32, TIMEOUT_CYCLES=16, CNT_WIDTH=2.
module tb_ftl_req_arbiter;
    import ftl_arb_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ftl_req_arbiter_if #(.NUM_REQ(2), .ADDR_WIDTH(32)) bus ();

    logic       busy, proto_err;
    logic [1:0] hit_cnt, miss_cnt;
    state_e     dbg_state;

    ftl_req_arbiter #(
        .NUM_REQ(2), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(16), .CNT_WIDTH(2)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .req_valid_i     (bus.req_valid),
        .req_ready_o     (bus.req_ready),
        .req_addr_i      (bus.req_addr),
        .req_rw_i        (bus.req_rw),
        .rsp_valid_o     (bus.rsp_valid),
        .rsp_addr_o      (bus.rsp_addr),
        .rsp_hit_o       (bus.rsp_hit),
        .rsp_err_o       (bus.rsp_err),
        .ftl_addr_o      (bus.ftl_addr),
        .ftl_addr_valid_o(bus.ftl_addr_valid),
        .ftl_rw_o        (bus.ftl_rw),
        .ftl_new_addr_i  (bus.ftl_new_addr),
        .ftl_addr_resp_i (bus.ftl_addr_resp),
        .ftl_cache_hit_i (bus.ftl_cache_hit),
        .busy_o          (busy),
        .proto_err_o     (proto_err),
        .hit_cnt_o       (hit_cnt),
        .miss_cnt_o      (miss_cnt),
        .dbg_state_o     (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int checks   = 0;
    int failures = 0;
    int issue_cnt = 0;
    int rsp_cnt   = 0;
    logic [1:0] exp_hit  = 2'd0;
    logic [1:0] exp_miss = 2'd0;
    int base_issue, base_rsp;

    always @(negedge clk) begin
        if (!rst && bus.ftl_addr_valid) issue_cnt++;
        if (bus.rsp_valid != 2'b00) rsp_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] sat_inc(input logic [1:0] v);
        return (v == 2'd3) ? 2'd3 : v + 2'd1;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input logic v, input logic [31:0] a, input logic rw);
        bus.req_valid[r]         = v;
        bus.req_addr[r*32 +: 32] = a;
        bus.req_rw[r]            = rw;
    endtask

    // One full transaction from IDLE: requester r issues a, FTL answers
    // ta/hit in the lat-th WAIT cycle (issue + lat cycles).
    task automatic do_txn(input int r, input logic [31:0] a, input logic rw, input int lat,
                          input logic [31:0] ta, input logic hit, input bit hold, input string tag);
        logic [1:0] onehot;
        onehot = (r == 0) ? 2'b01 : 2'b10;
        set_req(r, 1'b1, a, rw);
        #1;
        check({tag, "_ready"}, 64'(bus.req_ready), 64'(onehot));
        cyc();
        if (!hold) bus.req_valid[r] = 1'b0;
        #1;
        check({tag, "_issue"}, 64'(bus.ftl_addr_valid), 64'd1);
        check({tag, "_ftl_addr"}, 64'(bus.ftl_addr), 64'(a));
        check({tag, "_ftl_rw"}, 64'(bus.ftl_rw), 64'(rw));
        for (int k = 1; k < lat; k++) begin
            cyc();
            check({tag, "_wait_stable"}, {31'd0, bus.ftl_addr_valid, bus.ftl_addr}, {32'd0, a});
        end
        cyc();
        bus.ftl_addr_resp = 1'b1;
        bus.ftl_new_addr  = ta;
        bus.ftl_cache_hit = hit;
        cyc();
        bus.ftl_addr_resp = 1'b0;
        bus.ftl_cache_hit = 1'b0;
        if (hit) exp_hit = sat_inc(exp_hit);
        else     exp_miss = sat_inc(exp_miss);
        #1;
        check({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'(onehot));
        check({tag, "_rsp_addr"}, 64'(bus.rsp_addr), 64'(ta));
        check({tag, "_rsp_hit_err"}, {62'd0, bus.rsp_hit, bus.rsp_err}, {62'd0, hit, 1'b0});
        check({tag, "_addr_hold"}, 64'(bus.ftl_addr), 64'(a));
        check({tag, "_cnts"}, {60'd0, hit_cnt, miss_cnt}, {60'd0, exp_hit, exp_miss});
        cyc();
        check({tag, "_idle"}, {62'd0, busy, |bus.rsp_valid}, 64'd0);
        check({tag, "_rsp_hold"}, 64'(bus.rsp_addr), 64'(ta));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        bus.req_valid     = '0;
        bus.req_addr      = '0;
        bus.req_rw        = '0;
        bus.ftl_new_addr  = '0;
        bus.ftl_addr_resp = 1'b0;
        bus.ftl_cache_hit = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs",
              {bus.req_ready, bus.rsp_valid, bus.rsp_hit, bus.rsp_err, bus.ftl_addr_valid,
               bus.ftl_rw, busy, proto_err}, 64'd0);
        check("reset_addrs", {bus.rsp_addr, bus.ftl_addr}, 64'd0);
        check("reset_cnts", {60'd0, hit_cnt, miss_cnt}, 64'd0);
        check("reset_state", 64'(dbg_state), 64'(ST_IDLE));
        rst = 1'b0;
        cyc();

        // Single request, 4-cycle FTL latency, hit
        base_issue = issue_cnt;
        do_txn(0, 32'h0001_2345, 1'b0, 4, 32'h00AB_C345, 1'b1, 1'b0, "single");
        check("single_hit_cnt", 64'(hit_cnt), 64'd1);
        check("single_one_issue", 64'(issue_cnt - base_issue), 64'd1);

        // Requester 1 write, miss; leaves the pointer at 1
        do_txn(1, 32'h0000_0BEE, 1'b1, 2, 32'h0000_1BEE, 1'b0, 1'b0, "req1");

        // Contention: both held valid, expect 0,1,0,1,0,1
        set_req(0, 1'b1, 32'h0000_A000, 1'b0);
        set_req(1, 1'b1, 32'h0000_B000, 1'b1);
        for (int t = 0; t < 6; t++) begin
            if (t % 2 == 0)
                do_txn(0, 32'h0000_A000, 1'b0, 1 + t % 3, 32'h1000_0000 + 32'(t), 1'b0, 1'b1, "cont0");
            else
                do_txn(1, 32'h0000_B000, 1'b1, 1 + t % 3, 32'h2000_0000 + 32'(t), 1'b1, 1'b1, "cont1");
        end
        bus.req_valid = '0;

        // Timeout: accept at cycle 0, error response at cycle 18
        base_rsp = rsp_cnt;
        set_req(0, 1'b1, 32'h0000_7777, 1'b0);
        #1;
        check("to_ready", 64'(bus.req_ready), 64'd1);
        cyc();
        bus.req_valid = '0;
        check("to_issue", 64'(bus.ftl_addr_valid), 64'd1);
        for (int c = 2; c <= 17; c++) begin
            cyc();
            check("to_no_rsp", 64'(bus.rsp_valid), 64'd0);
        end
        cyc();
        check("to_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        check("to_rsp_err_hit", {62'd0, bus.rsp_err, bus.rsp_hit}, 64'd2);
        check("to_rsp_addr", 64'(bus.rsp_addr), 64'd0);
        check("to_cnts", {60'd0, hit_cnt, miss_cnt}, {60'd0, exp_hit, exp_miss});
        cyc();
        set_req(1, 1'b1, 32'h0000_5555, 1'b1);
        #1;
        check("drain_ready", 64'(bus.req_ready), 64'd0);
        check("drain_state", 64'(dbg_state), 64'(ST_DRAIN));
        for (int c = 20; c <= 40; c++) cyc();
        bus.ftl_addr_resp = 1'b1;
        bus.ftl_new_addr  = 32'hDEAD_BEEF;
        bus.ftl_cache_hit = 1'b1;
        cyc();
        bus.ftl_addr_resp = 1'b0;
        bus.ftl_cache_hit = 1'b0;
        #1;
        check("late_no_rsp", 64'(rsp_cnt - base_rsp), 64'd1);
        check("late_cnts", {60'd0, hit_cnt, miss_cnt}, {60'd0, exp_hit, exp_miss});
        check("late_no_proto", 64'(proto_err), 64'd0);
        check("late_ready", 64'(bus.req_ready), 64'd2);

        // Race: response in the last watchdog cycle wins
        do_txn(1, 32'h0000_5555, 1'b1, 16, 32'h0055_5555, 1'b1, 1'b0, "race");
        check("race_state", 64'(dbg_state), 64'(ST_IDLE));

        // Stray FTL response in IDLE
        base_rsp = rsp_cnt;
        bus.ftl_addr_resp = 1'b1;
        cyc();
        bus.ftl_addr_resp = 1'b0;
        check("proto_set", 64'(proto_err), 64'd1);
        cyc();
        check("proto_sticky", {62'd0, proto_err, busy}, 64'd2);
        check("proto_no_rsp", 64'(rsp_cnt - base_rsp), 64'd0);
        check("proto_cnts", {60'd0, hit_cnt, miss_cnt}, {60'd0, exp_hit, exp_miss});

        // Asynchronous reset during WAIT
        set_req(1, 1'b1, 32'h0000_9999, 1'b0);
        cyc();
        bus.req_valid = '0;
        cyc();
        cyc();
        check("rst_in_wait", 64'(dbg_state), 64'(ST_WAIT));
        bus.req_valid = 2'b10;
        #3;
        rst = 1'b1;
        #1;
        check("rst_async_outputs",
              {bus.req_ready, bus.rsp_valid, bus.rsp_hit, bus.rsp_err, bus.ftl_addr_valid,
               bus.ftl_rw, busy, proto_err}, 64'd0);
        check("rst_async_addrs", {bus.rsp_addr, bus.ftl_addr}, 64'd0);
        check("rst_async_cnts", {60'd0, hit_cnt, miss_cnt}, 64'd0);
        exp_hit  = 2'd0;
        exp_miss = 2'd0;
        bus.req_valid = '0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        base_rsp = rsp_cnt;
        for (int c = 0; c < 20; c++) cyc();
        check("rst_no_rsp", 64'(rsp_cnt - base_rsp), 64'd0);
        bus.req_valid = 2'b11;
        #1;
        check("rst_first_grant", 64'(bus.req_ready), 64'd1);
        bus.req_valid = '0;
        cyc();

        // Miss counter saturation at 3
        for (int n = 0; n < 5; n++) begin
            do_txn(0, 32'h0000_0100 + 32'(n), 1'b0, 1 + n, 32'h0300_0000 + 32'(n), 1'b0, 1'b0, "sat");
        end
        check("sat_miss_cnt", 64'(miss_cnt), 64'd3);
        check("sat_hit_cnt", 64'(hit_cnt), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
